// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_pkg
// Purpose  : Shared types and helpers for the rst_seq reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

  // Sequencer states, in boot order.
  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_POR_HOLD  = 3'd2,
    S_SYS_HOLD  = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  // Sticky reset-cause code; value 3 is never produced.
  typedef enum logic [1:0] {
    CAUSE_PIN       = 2'd0,
    CAUSE_LOCK_LOSS = 2'd1,
    CAUSE_SYSREQ    = 2'd2
  } cause_t;

  // Largest of three cycle counts, used to size the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq_sync2.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_sync2
// Purpose  : Two-flop synchroniser with asynchronous clear. Used both as the
//            reset release synchroniser (d_i tied high) and for lock flags.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; clear asserts asynchronously, release is synchronous.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq
// Purpose  : Reset sequencer for flexsoc_cm3. Waits for filtered PLL lock,
//            then releases PORESETn and later SYSRESETn; tracks reset cause.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_PLL     = 2,
  parameter int LOCK_FILTER = 4,
  parameter int POR_CYCLES  = 16,
  parameter int SYS_CYCLES  = 8
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic [NUM_PLL-1:0] PLL_LOCKED,
  input  logic               SYSRESETREQ,
  output logic               PORESETn,
  output logic               SYSRESETn,
  output logic [1:0]         RST_CAUSE
);

  localparam int CNT_MAX = max3(LOCK_FILTER, POR_CYCLES, SYS_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_LAST  = CNT_W'(SYS_CYCLES - 1);

  logic               rst_int_n;
  logic [NUM_PLL-1:0] lock_sync;
  logic               lock_ok;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  cause_t             cause_q, cause_d;
  logic               poresetn_q, poresetn_d;
  logic               sysresetn_q, sysresetn_d;

  // Pushbutton reset: asserts immediately, releases two edges after RESETn rises.
  rst_seq_sync2 #(.RESET_VAL(1'b0)) u_rst_sync (
    .clk_i  (CLK),
    .rst_ni (RESETn),
    .d_i    (1'b1),
    .q_o    (rst_int_n)
  );

  // Lock flags are cleared by the raw pin so they are settled by release.
  for (genvar gi = 0; gi < NUM_PLL; gi++) begin : g_pll_sync
    rst_seq_sync2 #(.RESET_VAL(1'b0)) u_lock_sync (
      .clk_i  (CLK),
      .rst_ni (RESETn),
      .d_i    (PLL_LOCKED[gi]),
      .q_o    (lock_sync[gi])
    );
  end

  assign lock_ok = &lock_sync;

  // State, counter, cause and registered output decodes.
  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= S_RESET;
      cnt_q       <= '0;
      cause_q     <= CAUSE_PIN;
      poresetn_q  <= 1'b0;
      sysresetn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      poresetn_q  <= poresetn_d;
      sysresetn_q <= sysresetn_d;
    end
  end

  // Next-state logic; counter clears on every state change, lock loss has priority.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    cause_d = cause_q;
    case (state_q)
      S_RESET: state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (!lock_ok)                cnt_d   = '0;
        else if (cnt_q == LOCK_LAST) state_d = S_POR_HOLD;
        else                         cnt_d   = cnt_q + CNT_W'(1);
      end
      S_POR_HOLD: begin
        if (!lock_ok) begin
          state_d = S_WAIT_LOCK;
          cause_d = CAUSE_LOCK_LOSS;
        end else if (cnt_q == POR_LAST) begin
          state_d = S_SYS_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SYS_HOLD: begin
        if (!lock_ok) begin
          state_d = S_WAIT_LOCK;
          cause_d = CAUSE_LOCK_LOSS;
        end else if (cnt_q == SYS_LAST) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!lock_ok) begin
          state_d = S_WAIT_LOCK;
          cause_d = CAUSE_LOCK_LOSS;
        end else if (SYSRESETREQ) begin
          state_d = S_SYS_HOLD;
          cause_d = CAUSE_SYSREQ;
        end
      end
      default: state_d = S_RESET;
    endcase
    poresetn_d  = (state_d == S_SYS_HOLD) || (state_d == S_RUN);
    sysresetn_d = (state_d == S_RUN);
  end

  assign PORESETn  = poresetn_q;
  assign SYSRESETn = sysresetn_q;
  assign RST_CAUSE = cause_q;

endmodule
`default_nettype wire
